// File: rtl/calc_control_unit_p_pkg.sv
// Shared key codes, FSM state encoding and operator decode for the calculator control unit.
package calc_control_unit_p_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_ADD       = 4'hA;
    localparam logic [3:0] KEY_SUB       = 4'hB;
    localparam logic [3:0] KEY_MUL       = 4'hC;
    localparam logic [3:0] KEY_DIV       = 4'hD;
    localparam logic [3:0] KEY_EQUAL     = 4'hE;
    localparam logic [3:0] KEY_CLEAR     = 4'hF;

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_OP_WAIT,
        ST_ENTRY_B,
        ST_EXEC,
        ST_COMMIT,
        ST_DIV_WAIT,
        ST_RESULT,
        ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    function automatic op_t key_to_op(input logic [3:0] key);
        case (key)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_NONE;
        endcase
    endfunction

    function automatic logic is_digit(input logic [3:0] key);
        return key <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/calc_control_unit_p_if.sv
// Keypad-in / display-out bus between debouncer, control unit and display driver.
interface calc_control_unit_p_if #(
    parameter int unsigned WIDTH = 16
);
    logic [3:0]       button;
    logic             is_pressed_next;
    logic [WIDTH-1:0] display;
    logic             error;
    logic             busy;
    logic             result_valid;

    modport master (
        output button, is_pressed_next,
        input  display, error, busy, result_valid
    );

    modport slave (
        input  button, is_pressed_next,
        output display, error, busy, result_valid
    );
endinterface

// File: rtl/calc_control_unit_p_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses WIDTH cycles after start.
module iter_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // quotient doubles as the dividend shift register; a set MSB of trial means the subtract borrowed
    always_comb begin
        shifted = {rem, quotient[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clock) begin
        if (reset || abort) begin
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            count    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                dvs      <= divisor;
                quotient <= dividend;
                count    <= CW'(WIDTH);
            end else if (count != '0) begin
                if (!trial[WIDTH]) begin
                    rem      <= trial[WIDTH-1:0];
                    quotient <= {quotient[WIDTH-2:0], 1'b1};
                end else begin
                    rem      <= shifted[WIDTH-1:0];
                    quotient <= {quotient[WIDTH-2:0], 1'b0};
                end
                count <= count - CW'(1);
                if (count == CW'(1)) done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/calc_control_unit_p.sv
// Calculator control unit: decimal operand entry, chained ADD/SUB/MUL/DIV with error detection.
module calc_control_unit_p
    import calc_control_unit_p_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    calc_control_unit_p_if.slave bus
);
    localparam int unsigned EW = WIDTH + 4;
    localparam int unsigned DW = $clog2(MAX_DIGITS + 1);

    state_t           state, state_n;
    op_t              op, op_n, next_op, next_op_n;
    logic [WIDTH-1:0] a, a_n, b, b_n, result, result_n, display, display_n;
    logic [DW-1:0]    digits, digits_n;
    logic             error, error_n, busy, busy_n, result_valid, result_valid_n;

    logic             div_start, div_done, key_clear, key_digit, key_eq, commit;
    op_t              key_op;
    logic [WIDTH-1:0] div_quotient, commit_val;
    logic [EW-1:0]    d_ext, a_app, b_app;
    logic             a_ok, b_ok;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;

    iter_divider #(.WIDTH(WIDTH)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .abort    (key_clear),
        .dividend (a),
        .divisor  (b),
        .quotient (div_quotient),
        .done     (div_done)
    );

    always_comb begin
        key_clear = bus.is_pressed_next && (bus.button == KEY_CLEAR);
        key_digit = bus.is_pressed_next && is_digit(bus.button);
        key_eq    = bus.is_pressed_next && (bus.button == KEY_EQUAL);
        key_op    = bus.is_pressed_next ? key_to_op(bus.button) : OP_NONE;
        // Operand growth is checked in 4 extra bits so an overflowing digit is simply dropped
        d_ext     = EW'(bus.button);
        a_app     = EW'(a) * EW'(10) + d_ext;
        b_app     = EW'(b) * EW'(10) + d_ext;
        a_ok      = (a_app[EW-1:WIDTH] == '0) && (digits < DW'(MAX_DIGITS));
        b_ok      = (b_app[EW-1:WIDTH] == '0) && (digits < DW'(MAX_DIGITS));
        sum       = {1'b0, a} + {1'b0, b};
        prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    always_comb begin
        state_n        = state;
        op_n           = op;
        next_op_n      = next_op;
        a_n            = a;
        b_n            = b;
        result_n       = result;
        display_n      = display;
        digits_n       = digits;
        error_n        = error;
        busy_n         = 1'b0;
        result_valid_n = 1'b0;
        div_start      = 1'b0;
        commit         = 1'b0;
        commit_val     = '0;

        unique case (state)
            ST_ENTRY_A: begin
                if (key_digit) begin
                    if (a_ok) begin
                        a_n       = a_app[WIDTH-1:0];
                        display_n = a_app[WIDTH-1:0];
                        digits_n  = digits + DW'(1);
                    end
                end else if (key_op != OP_NONE) begin
                    op_n    = key_op;
                    state_n = ST_OP_WAIT;
                end else if (key_eq) begin
                    result_n       = a;
                    result_valid_n = 1'b1;
                    state_n        = ST_RESULT;
                end
            end
            ST_OP_WAIT: begin
                if (key_digit) begin
                    b_n       = WIDTH'(bus.button);
                    display_n = WIDTH'(bus.button);
                    digits_n  = DW'(1);
                    state_n   = ST_ENTRY_B;
                end else if (key_op != OP_NONE) begin
                    op_n = key_op;
                end
            end
            ST_ENTRY_B: begin
                if (key_digit) begin
                    if (b_ok) begin
                        b_n       = b_app[WIDTH-1:0];
                        display_n = b_app[WIDTH-1:0];
                        digits_n  = digits + DW'(1);
                    end
                end else if (key_op != OP_NONE) begin
                    next_op_n = key_op;
                    state_n   = ST_EXEC;
                end else if (key_eq) begin
                    next_op_n = OP_NONE;
                    state_n   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_n = ST_COMMIT;
                unique case (op)
                    OP_ADD: begin
                        result_n = sum[WIDTH-1:0];
                        if (sum[WIDTH]) state_n = ST_ERROR;
                    end
                    OP_SUB: begin
                        result_n = a - b;
                        if (a < b) state_n = ST_ERROR;
                    end
                    OP_MUL: begin
                        result_n = prod[WIDTH-1:0];
                        if (prod[2*WIDTH-1:WIDTH] != '0) state_n = ST_ERROR;
                    end
                    OP_DIV: begin
                        if (b == '0) begin
                            state_n = ST_ERROR;
                        end else begin
                            div_start = 1'b1;
                            state_n   = ST_DIV_WAIT;
                        end
                    end
                    default: state_n = ST_ERROR;
                endcase
                if (state_n == ST_ERROR) begin
                    error_n   = 1'b1;
                    display_n = '0;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                commit_val = result;
            end
            ST_DIV_WAIT: begin
                if (div_done) begin
                    commit     = 1'b1;
                    commit_val = div_quotient;
                end else begin
                    busy_n = 1'b1;
                end
            end
            ST_RESULT: begin
                if (key_digit) begin
                    a_n       = WIDTH'(bus.button);
                    display_n = WIDTH'(bus.button);
                    digits_n  = DW'(1);
                    state_n   = ST_ENTRY_A;
                end else if (key_op != OP_NONE) begin
                    a_n     = result;
                    op_n    = key_op;
                    state_n = ST_OP_WAIT;
                end
            end
            ST_ERROR: ;
            default: state_n = ST_ENTRY_A;
        endcase

        // Shared by the single-cycle ops and the divider completion path
        if (commit) begin
            result_n       = commit_val;
            display_n      = commit_val;
            result_valid_n = 1'b1;
            if (next_op == OP_NONE) begin
                state_n = ST_RESULT;
            end else begin
                a_n       = commit_val;
                op_n      = next_op;
                next_op_n = OP_NONE;
                state_n   = ST_OP_WAIT;
            end
        end

        if (key_clear) begin
            state_n        = ST_ENTRY_A;
            op_n           = OP_NONE;
            next_op_n      = OP_NONE;
            a_n            = '0;
            b_n            = '0;
            result_n       = '0;
            display_n      = '0;
            digits_n       = '0;
            error_n        = 1'b0;
            busy_n         = 1'b0;
            result_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_ENTRY_A;
            op           <= OP_NONE;
            next_op      <= OP_NONE;
            a            <= '0;
            b            <= '0;
            result       <= '0;
            display      <= '0;
            digits       <= '0;
            error        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            op           <= op_n;
            next_op      <= next_op_n;
            a            <= a_n;
            b            <= b_n;
            result       <= result_n;
            display      <= display_n;
            digits       <= digits_n;
            error        <= error_n;
            busy         <= busy_n;
            result_valid <= result_valid_n;
        end
    end

    assign bus.display      = display;
    assign bus.error        = error;
    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
endmodule

// File: tb/tb_calc_control_unit_p.sv
// Directed bench for calc_control_unit_p (WIDTH=16, MAX_DIGITS=4) with hand-computed expectations.
module tb_calc_control_unit_p;
    import calc_control_unit_p_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;

    calc_control_unit_p_if #(.WIDTH(16)) bus ();

    calc_control_unit_p #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic press(input logic [3:0] key);
        @(negedge clock);
        bus.button          = key;
        bus.is_pressed_next = 1'b1;
        @(negedge clock);
        bus.is_pressed_next = 1'b0;
    endtask

    task automatic enter(input int unsigned value);
        int unsigned v = value;
        int unsigned p = 1;
        while (p * 10 <= v) p = p * 10;
        do begin
            press(4'(v / p));
            v = v % p;
            p = p / 10;
        end while (p > 0);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic test_reset;
        total++; if (bus.display !== 16'd0) begin bad++; $display("FAIL reset_display: got %0d want 0", bus.display); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error: got %0b want 0", bus.error); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %0b want 0", bus.result_valid); end
    endtask

    task automatic test_add;
        press(KEY_CLEAR); press(4'd3); press(KEY_ADD); press(4'd2); press(KEY_EQUAL);
        total++; if (bus.display !== 16'd2) begin bad++; $display("FAIL add_operand_b: got %0d want 2", bus.display); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL add_rv_n0: got %0b want 0", bus.result_valid); end
        idle(1);
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL add_rv_n1: got %0b want 0", bus.result_valid); end
        idle(1);
        total++; if (bus.display !== 16'd5) begin bad++; $display("FAIL add_result: got %0d want 5", bus.display); end
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL add_rv_n2: got %0b want 1", bus.result_valid); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL add_error: got %0b want 0", bus.error); end
        idle(1);
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL add_rv_n3: got %0b want 0", bus.result_valid); end
    endtask

    task automatic test_div_and_reuse;
        int unsigned first_busy = 0, busy_cnt = 0, rv_cnt = 0, rv_at = 0;
        logic [15:0] disp_at_rv = '0;
        press(KEY_CLEAR); press(4'd7); press(KEY_DIV); press(4'd4); press(KEY_EQUAL);
        for (int unsigned i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = i;
            end
            if (bus.result_valid === 1'b1) begin
                rv_cnt++;
                rv_at = i;
                disp_at_rv = bus.display;
            end
        end
        total++; if (first_busy != 2) begin bad++; $display("FAIL div_busy_start: got %0d want 2", first_busy); end
        total++; if (busy_cnt != 16) begin bad++; $display("FAIL div_busy_len: got %0d want 16", busy_cnt); end
        total++; if (rv_cnt != 1) begin bad++; $display("FAIL div_rv_count: got %0d want 1", rv_cnt); end
        total++; if (rv_at != 18) begin bad++; $display("FAIL div_rv_cycle: got %0d want 18", rv_at); end
        total++; if (disp_at_rv !== 16'd1) begin bad++; $display("FAIL div_quotient: got %0d want 1", disp_at_rv); end
        press(KEY_ADD); press(4'd7); press(KEY_EQUAL); idle(2);
        total++; if (bus.display !== 16'd8) begin bad++; $display("FAIL reuse_result: got %0d want 8", bus.display); end
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL reuse_rv: got %0b want 1", bus.result_valid); end
    endtask

    task automatic test_chain;
        press(KEY_CLEAR); press(4'd2); press(KEY_ADD); press(4'd3); press(KEY_MUL); idle(2);
        total++; if (bus.display !== 16'd5) begin bad++; $display("FAIL chain_mid: got %0d want 5", bus.display); end
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL chain_mid_rv: got %0b want 1", bus.result_valid); end
        press(4'd4); press(KEY_EQUAL); idle(2);
        total++; if (bus.display !== 16'd20) begin bad++; $display("FAIL chain_final: got %0d want 20", bus.display); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL chain_error: got %0b want 0", bus.error); end
    endtask

    task automatic test_digit_limits;
        press(KEY_CLEAR); enter(12345);
        total++; if (bus.display !== 16'd1234) begin bad++; $display("FAIL digits_max: got %0d want 1234", bus.display); end
        press(KEY_CLEAR); enter(65536);
        total++; if (bus.display !== 16'd6553) begin bad++; $display("FAIL digits_overflow: got %0d want 6553", bus.display); end
        press(KEY_EQUAL);
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL equal_a_rv: got %0b want 1", bus.result_valid); end
        total++; if (bus.display !== 16'd6553) begin bad++; $display("FAIL equal_a_display: got %0d want 6553", bus.display); end
        idle(1);
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL equal_a_rv_end: got %0b want 0", bus.result_valid); end
    endtask

    task automatic test_errors;
        press(KEY_CLEAR); press(4'd5); press(KEY_DIV); press(4'd0); press(KEY_EQUAL); idle(2);
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL div0_error: got %0b want 1", bus.error); end
        total++; if (bus.display !== 16'd0) begin bad++; $display("FAIL div0_display: got %0d want 0", bus.display); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL div0_busy: got %0b want 0", bus.busy); end
        press(4'd9);
        total++; if (bus.display !== 16'd0) begin bad++; $display("FAIL err_digit_display: got %0d want 0", bus.display); end
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", bus.error); end
        press(KEY_CLEAR);
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL err_clear: got %0b want 0", bus.error); end
        total++; if (bus.display !== 16'd0) begin bad++; $display("FAIL err_clear_display: got %0d want 0", bus.display); end

        press(4'd2); press(KEY_SUB); press(4'd3); press(KEY_EQUAL); idle(2);
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL sub_borrow: got %0b want 1", bus.error); end
        press(KEY_CLEAR);
        enter(300); press(KEY_MUL); enter(300); press(KEY_EQUAL); idle(2);
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL mul_overflow: got %0b want 1", bus.error); end
        press(KEY_CLEAR);
        enter(255); press(KEY_MUL); enter(257); press(KEY_EQUAL); idle(2);
        total++; if (bus.display !== 16'd65535) begin bad++; $display("FAIL mul_max: got %0d want 65535", bus.display); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL mul_max_error: got %0b want 0", bus.error); end
        press(KEY_CLEAR);
        press(4'd5); press(KEY_SUB); press(4'd5); press(KEY_EQUAL); idle(2);
        total++; if (bus.result_valid !== 1'b1 || bus.error !== 1'b0) begin bad++; $display("FAIL sub_zero: got rv=%0b err=%0b want rv=1 err=0", bus.result_valid, bus.error); end
        press(KEY_CLEAR);
        enter(9999); press(KEY_MUL); press(4'd6); press(KEY_ADD); idle(2);
        total++; if (bus.display !== 16'd59994) begin bad++; $display("FAIL carry_mid: got %0d want 59994", bus.display); end
        enter(5542); press(KEY_EQUAL); idle(2);
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL add_carry: got %0b want 1", bus.error); end
        press(KEY_CLEAR);
    endtask

    task automatic test_clear_mid_div;
        int unsigned rv_cnt = 0;
        press(KEY_CLEAR); enter(99); press(KEY_DIV); press(4'd3); press(KEY_EQUAL); idle(5);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %0b want 1", bus.busy); end
        press(KEY_CLEAR);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", bus.busy); end
        total++; if (bus.display !== 16'd0) begin bad++; $display("FAIL abort_display: got %0d want 0", bus.display); end
        for (int unsigned i = 0; i < 25; i++) begin
            if (bus.result_valid === 1'b1) rv_cnt++;
            @(negedge clock);
        end
        total++; if (rv_cnt != 0) begin bad++; $display("FAIL abort_no_rv: got %0d want 0", rv_cnt); end
    endtask

    task automatic test_reset_entry_b;
        press(KEY_CLEAR); press(4'd4); press(KEY_ADD); press(4'd5);
        total++; if (bus.display !== 16'd5) begin bad++; $display("FAIL entry_b_display: got %0d want 5", bus.display); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++; if ({bus.display, bus.error, bus.busy, bus.result_valid} !== 19'd0) begin bad++; $display("FAIL reset_entry_b: got disp=%0d err=%0b busy=%0b rv=%0b want all 0", bus.display, bus.error, bus.busy, bus.result_valid); end
        press(4'd3);
        total++; if (bus.display !== 16'd3) begin bad++; $display("FAIL reset_entry_a: got %0d want 3", bus.display); end
    endtask

    initial begin
        bus.button          = 4'd0;
        bus.is_pressed_next = 1'b0;
        idle(3);
        reset = 1'b0;
        test_reset();
        test_add();
        test_div_and_reuse();
        test_chain();
        test_digit_limits();
        test_errors();
        test_clear_mid_div();
        test_reset_entry_b();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
